// File: rtl/ip_scheduler_pkg.sv
// Shared types and default sizing for the key-switching inner-product scheduler.
// Holds the job geometry, its derived address widths and the FSM state encoding.
package ip_scheduler_pkg;

   localparam int N_DEF  = 1024;
   localparam int L_DEF  = 30;
   localparam int W_DEF  = 30;
   localparam int KW_DEF = $clog2(N_DEF);
   localparam int DW_DEF = $clog2(L_DEF);
   localparam int RW_DEF = KW_DEF + DW_DEF;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      MAC,
      DRAIN,
      EMIT,
      FIN
   } state_t;

endpackage

// File: rtl/ip_scheduler_if.sv
// Memory read ports and result stream between the scheduler and its surroundings.
// The master side is the scheduler; the slave side is the memories and the sink.
interface ip_scheduler_if import ip_scheduler_pkg::*; #(
   parameter int N = N_DEF,
   parameter int L = L_DEF,
   parameter int W = W_DEF
) ();

   localparam int KW = $clog2(N);
   localparam int DW = $clog2(L);

   logic             ct_rd;
   logic [KW-1:0]    ct_addr;
   logic [W-1:0]     ct_rdata;
   logic             rlk_rd;
   logic [KW+DW-1:0] rlk_addr;
   logic [W-1:0]     rlk_rdata;
   logic             res_valid;
   logic [KW-1:0]    res_addr;
   logic [W-1:0]     res_data;
   logic             res_ready;

   modport master (
      output ct_rd, ct_addr, input ct_rdata,
      output rlk_rd, rlk_addr, input rlk_rdata,
      output res_valid, res_addr, res_data, input res_ready
   );

   modport slave (
      input ct_rd, ct_addr, output ct_rdata,
      input rlk_rd, rlk_addr, output rlk_rdata,
      input res_valid, res_addr, res_data, output res_ready
   );

endinterface

// File: rtl/ip_scheduler_arb.sv
// Two-way round-robin arbiter: on contention the requester not served last wins.
module rr_arbiter2 (
   input  logic [1:0] req,
   input  logic       last_served,
   output logic [1:0] grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_served ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

endmodule

// File: rtl/ip_scheduler.sv
// Shares one digit-serial inner-product engine between two requesters.
// Each coefficient: read ct, walk L key digits adding those selected by ct bits, emit.
module ip_scheduler import ip_scheduler_pkg::*; #(
   parameter int N = N_DEF,
   parameter int L = L_DEF,
   parameter int W = W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [1:0]     req,
   output logic [1:0]     grant,
   output logic [1:0]     done,
   output logic           busy,
   ip_scheduler_if.master mem
);

   localparam int KW = $clog2(N);
   localparam int DW = $clog2(L);
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);
   localparam logic [DW-1:0] D_LAST = DW'(L - 1);

   state_t        state;
   logic [KW-1:0] k;
   logic [DW-1:0] d;
   logic [DW-1:0] d_prev;
   logic          owner;
   logic          last_served;
   logic [1:0]    arb_grant;
   logic [W-1:0]  ct_reg;
   logic [W-1:0]  acc;
   logic          ct_cap;
   logic          mac_pend;

   rr_arbiter2 u_arb (
      .req         (req),
      .last_served (last_served),
      .grant       (arb_grant)
   );

   // Control FSM; every strobe is registered on the transition into its state.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         grant         <= '0;
         done          <= '0;
         busy          <= 1'b0;
         mem.ct_rd     <= 1'b0;
         mem.rlk_rd    <= 1'b0;
         mem.res_valid <= 1'b0;
         k             <= '0;
         d             <= '0;
         owner         <= 1'b0;
         last_served   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (req != 2'b00) begin
                  grant     <= arb_grant;
                  owner     <= arb_grant[1];
                  busy      <= 1'b1;
                  mem.ct_rd <= 1'b1;
                  k         <= '0;
                  state     <= LOAD;
               end
            end
            LOAD: begin
               mem.ct_rd  <= 1'b0;
               mem.rlk_rd <= 1'b1;
               d          <= '0;
               state      <= MAC;
            end
            MAC: begin
               if (d == D_LAST) begin
                  mem.rlk_rd <= 1'b0;
                  d          <= '0;
                  state      <= DRAIN;
               end else begin
                  d <= d + 1'b1;
               end
            end
            DRAIN: begin
               mem.res_valid <= 1'b1;
               state         <= EMIT;
            end
            EMIT: begin
               if (mem.res_ready) begin
                  mem.res_valid <= 1'b0;
                  if (k == K_LAST) begin
                     k           <= '0;
                     done[owner] <= 1'b1;
                     state       <= FIN;
                  end else begin
                     k         <= k + 1'b1;
                     mem.ct_rd <= 1'b1;
                     state     <= LOAD;
                  end
               end
            end
            FIN: begin
               done        <= '0;
               grant       <= '0;
               busy        <= 1'b0;
               last_served <= owner;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read data lands one cycle after each strobe, so the datapath trails the FSM by a cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         acc      <= '0;
         ct_reg   <= '0;
         ct_cap   <= 1'b0;
         mac_pend <= 1'b0;
         d_prev   <= '0;
      end else begin
         ct_cap   <= mem.ct_rd;
         mac_pend <= mem.rlk_rd;
         d_prev   <= d;
         if (ct_cap) begin
            ct_reg <= mem.ct_rdata;
         end
         if (state == LOAD) begin
            acc <= '0;
         end else if (mac_pend && ct_reg[d_prev]) begin
            acc <= acc + mem.rlk_rdata;
         end
      end
   end

   assign mem.ct_addr  = k;
   assign mem.rlk_addr = {k, d};
   assign mem.res_addr = k;
   assign mem.res_data = acc;

endmodule

// File: tb/tb_ip_scheduler.sv
// Directed bench for ip_scheduler: arbitration, datapath values, stalls, aborts and timing.
module tb_ip_scheduler;

   localparam int TN  = 16;
   localparam int TL  = 30;
   localparam int TW  = 30;
   localparam int KW  = $clog2(TN);
   localparam int DW  = $clog2(TL);
   localparam int JOB = TN * (TL + 3);

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] req;
   logic [1:0] grant;
   logic [1:0] done;
   logic       busy;

   int cyc   = 0;
   int t0    = 0;
   int n_cmp = 0;
   int n_bad = 0;
   int n_res = 0;
   int exp_k = 0;
   int mode  = 0;

   ip_scheduler_if #(.N(TN), .L(TL), .W(TW)) bus ();

   ip_scheduler #(.N(TN), .L(TL), .W(TW)) dut (
      .clk   (clk),
      .reset (reset),
      .req   (req),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .mem   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
      end
   endtask

   // Mode 0: all ct bits set, unit keys. Mode 1: wrap case. Mode 2: bank-dependent ct.
   function automatic logic [TW-1:0] ctValue(input logic bank, input logic [KW-1:0] kk);
      case (mode)
         1:       return kk[0] ? TW'(3) : TW'(1);
         2:       return bank ? TW'(5) : TW'(30'h3FFF_FFFF);
         default: return TW'(30'h3FFF_FFFF);
      endcase
   endfunction

   function automatic logic [TW-1:0] rlkValue(input logic [DW-1:0] dg);
      case (mode)
         1:       return (dg == 0) ? TW'(30'h3FFF_FFFF) : (dg == 1) ? TW'(5) : TW'(30'h155);
         2:       return TW'(dg) + TW'(1);
         default: return TW'(1);
      endcase
   endfunction

   function automatic logic [TW-1:0] expData(input logic bank, input int kk);
      case (mode)
         1:       return kk[0] ? TW'(4) : TW'(30'h3FFF_FFFF);
         2:       return bank ? TW'(4) : TW'(465);
         default: return TW'(30);
      endcase
   endfunction

   always @(posedge clk) begin
      if (bus.ct_rd)  bus.ct_rdata  <= ctValue(grant[1], bus.ct_addr);
      if (bus.rlk_rd) bus.rlk_rdata <= rlkValue(bus.rlk_addr[DW-1:0]);
   end

   // Per-cycle invariants plus in-order checking of every accepted result.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         checkOutput("grant_onehot", $countones(grant) <= 1, 1);
         checkOutput("strobe_exclusive", $countones({bus.ct_rd, bus.rlk_rd, bus.res_valid}) <= 1, 1);
         checkOutput("busy_vs_grant", busy, grant != 2'b00);
         if (bus.res_valid && bus.res_ready) begin
            checkOutput("res_addr", bus.res_addr, exp_k);
            checkOutput("res_data", bus.res_data, expData(grant[1], exp_k));
            exp_k = (exp_k == TN - 1) ? 0 : exp_k + 1;
            n_res++;
         end
      end
   end

   task automatic applyStimulus(input logic [1:0] r, input int m);
      @(posedge clk);
      #1;
      mode  = m;
      req   = r;
      n_res = 0;
      exp_k = 0;
      t0    = cyc;
   endtask

   task automatic waitDone(input string tag, input logic [1:0] want, input int budget, output int edge_n);
      int i = 0;
      while (done == 2'b00 && i < budget) begin
         @(negedge clk);
         i++;
      end
      checkOutput(tag, done, want);
      edge_n = cyc + 1 - t0;
   endtask

   task automatic checkIdle(input string pfx);
      checkOutput({pfx, "_grant"},     grant, 0);
      checkOutput({pfx, "_done"},      done, 0);
      checkOutput({pfx, "_busy"},      busy, 0);
      checkOutput({pfx, "_ct_rd"},     bus.ct_rd, 0);
      checkOutput({pfx, "_rlk_rd"},    bus.rlk_rd, 0);
      checkOutput({pfx, "_res_valid"}, bus.res_valid, 0);
      checkOutput({pfx, "_acc"},       bus.res_data, 0);
      checkOutput({pfx, "_k"},         bus.res_addr, 0);
      checkOutput({pfx, "_rlk_addr"},  bus.rlk_addr, 0);
   endtask

   initial begin
      int e;
      reset         = 1'b1;
      req           = 2'b00;
      bus.res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkIdle("reset");
      reset = 1'b0;

      // Both request out of reset: requester 0 first, then 1 after one idle cycle.
      applyStimulus(2'b11, 2);
      @(negedge clk);
      checkOutput("pre_grant", grant, 0);
      @(negedge clk);
      checkOutput("rr_first_grant", grant, 2'b01);
      checkOutput("load_ct_rd", bus.ct_rd, 1);
      checkOutput("load_ct_addr", bus.ct_addr, 0);
      waitDone("rr_done0", 2'b01, JOB + 10, e);
      checkOutput("rr_results0", n_res, TN);
      req   = 2'b10;
      n_res = 0;
      @(negedge clk);
      checkOutput("rr_idle_gap", grant, 0);
      @(negedge clk);
      checkOutput("rr_second_grant", grant, 2'b10);
      waitDone("rr_done1", 2'b10, JOB + 10, e);
      checkOutput("rr_results1", n_res, TN);
      req = 2'b00;

      // Single job with default-style data; done closes at edge JOB+2 after req.
      applyStimulus(2'b01, 0);
      repeat (2) @(negedge clk);
      checkOutput("t_grant", grant, 2'b01);
      @(negedge clk);
      checkOutput("mac_rlk_rd", bus.rlk_rd, 1);
      checkOutput("mac_rlk_addr0", bus.rlk_addr, 0);
      @(negedge clk);
      checkOutput("mac_rlk_addr1", bus.rlk_addr, 1);
      waitDone("t_done", 2'b01, JOB + 10, e);
      checkOutput("t_latency", e, JOB + 2);
      checkOutput("t_results", n_res, TN);
      req = 2'b00;

      // Requester 0 was served last, so 1 wins; 0 stays pending and goes next.
      applyStimulus(2'b11, 2);
      repeat (2) @(negedge clk);
      checkOutput("rr_turn_grant", grant, 2'b10);
      waitDone("rr_turn_done1", 2'b10, JOB + 10, e);
      req   = 2'b01;
      n_res = 0;
      repeat (2) @(negedge clk);
      checkOutput("pending_grant", grant, 2'b01);
      waitDone("pending_done0", 2'b01, JOB + 10, e);
      checkOutput("pending_results", n_res, TN);
      req = 2'b00;

      // Sink stalls for 7 cycles on coefficient 5.
      applyStimulus(2'b01, 1);
      for (int i = 0; i < JOB && !(bus.ct_rd && bus.ct_addr == KW'(5)); i++) @(negedge clk);
      bus.res_ready = 1'b0;
      for (int i = 0; i < 100 && !bus.res_valid; i++) @(negedge clk);
      checkOutput("stall_addr", bus.res_addr, 5);
      checkOutput("stall_data", bus.res_data, 4);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("stall_valid", bus.res_valid, 1);
         checkOutput("stall_hold", {bus.res_addr, bus.res_data}, {KW'(5), TW'(4)});
         checkOutput("stall_no_reads", {bus.ct_rd, bus.rlk_rd}, 0);
      end
      @(posedge clk);
      #1 bus.res_ready = 1'b1;
      waitDone("stall_done", 2'b01, JOB + 20, e);
      checkOutput("stall_latency", e, JOB + 2 + 7);
      checkOutput("stall_results", n_res, TN);
      req = 2'b00;

      // Abort in the middle of coefficient 8's digit walk, then rerun from k=0.
      applyStimulus(2'b01, 0);
      for (int i = 0; i < JOB && !(bus.rlk_rd && bus.rlk_addr == {KW'(8), DW'(10)}); i++) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      checkIdle("abort");
      reset = 1'b0;
      exp_k = 0;
      n_res = 0;
      t0    = cyc;
      waitDone("restart_done", 2'b01, JOB + 10, e);
      checkOutput("restart_latency", e, JOB + 2);
      checkOutput("restart_results", n_res, TN);
      req = 2'b00;

      // Request withdrawn early: the job still completes.
      applyStimulus(2'b01, 1);
      repeat (10) @(posedge clk);
      #1 req = 2'b00;
      waitDone("drop_done", 2'b01, JOB + 10, e);
      checkOutput("drop_latency", e, JOB + 2);
      checkOutput("drop_results", n_res, TN);
      @(negedge clk);
      checkOutput("drop_idle_busy", busy, 0);
      checkOutput("drop_idle_grant", grant, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ip_scheduler.md
IP_SCHEDULER -- requirements
Module: ip_scheduler

Interface
REQ-001 SHALL have parameters: N, default 1024, coefficients per job; L, default 30, decomposition digits per coefficient; W, default 30, coefficient width.
REQ-002 SHALL have port clk, input, 1, clock; reset reset, synchronous, active-high; clock clk.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port req, input, 2, per-requester job request, level, held until done.
REQ-005 SHALL have port grant, output, 2, one-hot owner of the engine, zero when idle.
REQ-006 SHALL have port done, output, 2, one-cycle pulse on the owner's bit at job completion.
REQ-007 SHALL have ports ct_rd (output, 1), ct_addr (output, log2 N), ct_rdata (input, W): ciphertext read port, 1-cycle read latency, bank selected externally by grant.
REQ-008 SHALL have ports rlk_rd (output, 1), rlk_addr (output, log2 N + 5, {coef, digit}), rlk_rdata (input, W): key read port, 1-cycle latency.
REQ-009 SHALL have ports res_valid (output, 1), res_addr (output, log2 N), res_data (output, W), res_ready (input, 1): result stream.
REQ-010 SHALL have port busy, output, 1, high in every non-IDLE state.

Function
REQ-011 SHALL implement states IDLE, LOAD, MAC, DRAIN, EMIT, FIN.
REQ-012 IDLE: when req != 0, grant SHALL be set the next cycle and the FSM SHALL enter LOAD with coefficient index k=0.
REQ-013 Arbitration SHALL be round-robin: with both req bits set, the requester not served last wins; after reset, requester 0 has priority.
REQ-014 LOAD (1 cycle): ct_rd=1, ct_addr=k, accumulator cleared to 0, digit counter d=0.
REQ-015 MAC (L cycles): rlk_rd=1, rlk_addr={k,d}, d increments 0..L-1; ct_rdata SHALL be captured into ct_reg on the first MAC cycle.
REQ-016 Each cycle after an rlk read (MAC cycles 2..L and DRAIN), acc SHALL become (acc + (ct_reg[d_prev] ? rlk_rdata : 0)) mod 2^W, digit d_prev using ct bit d_prev, LSB first.
REQ-017 DRAIN (1 cycle): final accumulation, no memory reads.
REQ-018 EMIT: res_valid=1, res_addr=k, res_data=acc, held stable until res_ready; on handshake k increments and FSM goes to LOAD, or to FIN if k==N-1.
REQ-019 Per-coefficient latency with res_ready tied high SHALL be L+3 cycles (33 at defaults); job of N coefficients SHALL take N*(L+3) cycles from LOAD entry to final handshake.
REQ-020 FIN (1 cycle): done[owner]=1, grant cleared, last-served updated, return to IDLE; a re-request is arbitrated in IDLE the following cycle.
REQ-021 Deassertion of req during a job SHALL be ignored; the job SHALL run to completion.
REQ-022 A new req from the non-owner during a job SHALL be held pending and served next by REQ-013.
REQ-023 ct_rd, rlk_rd, res_valid SHALL never be asserted in the same cycle as one another.
REQ-024 k wrap at N-1 and d wrap at L-1 SHALL not overflow into address MSBs.

Reset
REQ-025 On reset: state IDLE, grant=0, done=0, busy=0, ct_rd=0, rlk_rd=0, res_valid=0, k=0, d=0, acc=0, last-served=1.
REQ-026 Reset mid-job SHALL abort without a done pulse; the next job restarts at k=0.

Structure
REQ-027 Shared package SHALL hold N, L, W, the state enumeration and derived address widths.
REQ-028 Round-robin arbiter SHALL be one sub-module, rr_arbiter2 (req, last-served in; one-hot grant out).
REQ-029 Datapath (ct_reg, acc, masked adder) SHALL stay inline; no multipliers.

Verification
REQ-030 req=01, ct[k]=0x3FFFFFFF, rlk[k][d]=1 for all d, res_ready=1 -> each res_data=30, done[0] pulse at cycle N*33+2 after req.
REQ-031 ct[k]=1, rlk[k][0]=0x3FFFFFFF, rlk[k][1]=5 -> res_data=0x3FFFFFFF; ct[k]=3 -> res_data=4 (mod 2^30 wrap).
REQ-032 req=11 from reset -> requester 0 served first, then requester 1 without a gap beyond one IDLE cycle; grant never two-hot.
REQ-033 res_ready low for 7 cycles at k=5 -> res_data/res_addr stable, no memory reads, total time +7 cycles.
REQ-034 reset asserted at k=512 mid-MAC -> all outputs at REQ-025 values next cycle, no done; new req completes normally from k=0.
REQ-035 req=01 dropped after 10 cycles -> full N results produced, done[0] still pulses.
